// File: rtl/mem_bus_arb_if.sv
// AXI4-Lite bus between the request arbiter (master) and the SoC interconnect (slave).
interface mem_bus_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // write address channel
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awsize;
  // write data channel
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  // write response channel
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  // read address channel
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arsize;
  // read data channel
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awsize,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arsize,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awsize,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arsize,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/mem_bus_arb.sv
// Serialises the core's fetch and load/store request ports onto one AXI4-Lite
// master port. One transaction in flight; LSU has fixed priority over IFU.
// Every output comes straight from a flop.
module mem_bus_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  // instruction fetch client
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  // load/store client
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [1:0]          lsu_size,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                bus_err,
  // interconnect side
  mem_bus_arb_if.master       axi
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_RESP = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  localparam logic CLI_IFU = 1'b0;
  localparam logic CLI_LSU = 1'b1;

  // fetches are always full words
  localparam logic [2:0] FETCH_SIZE = 3'b010;

  logic [2:0]          state_reg,     state_next;

  // request latched at grant; client inputs are not looked at afterwards
  logic                cli_reg,       cli_next;
  logic [ADDR_W-1:0]   addr_reg,      addr_next;
  logic [2:0]          size_reg,      size_next;
  logic                wen_reg,       wen_next;
  logic [DATA_W-1:0]   wdata_reg,     wdata_next;
  logic [DATA_W/8-1:0] wmask_reg,     wmask_next;

  // AXI handshake state
  logic                arvalid_reg,   arvalid_next;
  logic                rready_reg,    rready_next;
  logic                awvalid_reg,   awvalid_next;
  logic                wvalid_reg,    wvalid_next;
  logic                bready_reg,    bready_next;
  logic                aw_done_reg,   aw_done_next;
  logic                w_done_reg,    w_done_next;

  // client-facing results
  logic                ifu_resp_reg,  ifu_resp_next;
  logic                lsu_resp_reg,  lsu_resp_next;
  logic [DATA_W-1:0]   ifu_rdata_reg, ifu_rdata_next;
  logic [DATA_W-1:0]   lsu_rdata_reg, lsu_rdata_next;
  logic                bus_err_reg,   bus_err_next;

  logic                aw_hs;
  logic                w_hs;
  logic                r_hs;
  logic                b_hs;

  assign aw_hs = awvalid_reg && axi.awready;
  assign w_hs  = wvalid_reg  && axi.wready;
  assign r_hs  = rready_reg  && axi.rvalid;
  assign b_hs  = bready_reg  && axi.bvalid;

  // Next-state: grant in IDLE, then walk the AXI channels of the granted request.
  always_comb begin
    state_next     = state_reg;
    cli_next       = cli_reg;
    addr_next      = addr_reg;
    size_next      = size_reg;
    wen_next       = wen_reg;
    wdata_next     = wdata_reg;
    wmask_next     = wmask_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    ifu_rdata_next = ifu_rdata_reg;
    lsu_rdata_next = lsu_rdata_reg;
    // response strobes are pulses: low unless set below
    ifu_resp_next  = 1'b0;
    lsu_resp_next  = 1'b0;
    bus_err_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (lsu_reqValid) begin
          cli_next   = CLI_LSU;
          addr_next  = lsu_addr;
          size_next  = {1'b0, lsu_size};
          wen_next   = lsu_wen;
          wdata_next = lsu_wdata;
          wmask_next = lsu_wmask;
          if (lsu_wen) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = ST_WR_REQ;
          end else begin
            arvalid_next = 1'b1;
            state_next   = ST_RD_REQ;
          end
        end else if (ifu_reqValid) begin
          cli_next     = CLI_IFU;
          addr_next    = ifu_addr;
          size_next    = FETCH_SIZE;
          wen_next     = 1'b0;
          wdata_next   = '0;
          wmask_next   = '0;
          arvalid_next = 1'b1;
          state_next   = ST_RD_REQ;
        end
      end

      ST_RD_REQ: begin
        // araddr/arsize come from the latched request, so they stay stable
        if (axi.arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        if (r_hs) begin
          rready_next  = 1'b0;
          bus_err_next = (axi.rresp != 2'b00);
          if (cli_reg == CLI_LSU) begin
            lsu_rdata_next = axi.rdata;
            lsu_resp_next  = 1'b1;
          end else begin
            ifu_rdata_next = axi.rdata;
            ifu_resp_next  = 1'b1;
          end
          state_next = ST_IDLE;
        end
      end

      ST_WR_REQ: begin
        // AW and W complete independently, possibly in the same cycle
        if (aw_hs) begin
          awvalid_next = 1'b0;
        end
        if (w_hs) begin
          wvalid_next = 1'b0;
        end
        aw_done_next = aw_done_reg || aw_hs;
        w_done_next  = w_done_reg  || w_hs;
        if (aw_done_next && w_done_next) begin
          bready_next = 1'b1;
          state_next  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (b_hs) begin
          bready_next   = 1'b0;
          lsu_resp_next = 1'b1;
          bus_err_next  = (axi.bresp != 2'b00);
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
          state_next    = ST_IDLE;
        end
      end

      default: begin
        arvalid_next = 1'b0;
        rready_next  = 1'b0;
        awvalid_next = 1'b0;
        wvalid_next  = 1'b0;
        bready_next  = 1'b0;
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  // FSM state and the latched request fields.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cli_reg   <= CLI_IFU;
      addr_reg  <= '0;
      size_reg  <= '0;
      wen_reg   <= 1'b0;
      wdata_reg <= '0;
      wmask_reg <= '0;
    end else begin
      state_reg <= state_next;
      cli_reg   <= cli_next;
      addr_reg  <= addr_next;
      size_reg  <= size_next;
      wen_reg   <= wen_next;
      wdata_reg <= wdata_next;
      wmask_reg <= wmask_next;
    end
  end

  // AXI valid/ready flops and write-channel completion flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  // Client response pulses, per-client read data and the error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ifu_resp_reg  <= 1'b0;
      lsu_resp_reg  <= 1'b0;
      ifu_rdata_reg <= '0;
      lsu_rdata_reg <= '0;
      bus_err_reg   <= 1'b0;
    end else begin
      ifu_resp_reg  <= ifu_resp_next;
      lsu_resp_reg  <= lsu_resp_next;
      ifu_rdata_reg <= ifu_rdata_next;
      lsu_rdata_reg <= lsu_rdata_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  assign ifu_respValid = ifu_resp_reg;
  assign ifu_rdata     = ifu_rdata_reg;
  assign lsu_respValid = lsu_resp_reg;
  assign lsu_rdata     = lsu_rdata_reg;
  assign bus_err       = bus_err_reg;

  assign axi.arvalid = arvalid_reg;
  assign axi.araddr  = addr_reg;
  assign axi.arsize  = size_reg;
  assign axi.rready  = rready_reg;
  assign axi.awvalid = awvalid_reg;
  assign axi.awaddr  = addr_reg;
  assign axi.awsize  = size_reg;
  assign axi.wvalid  = wvalid_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.wstrb   = wmask_reg;
  assign axi.bready  = bready_reg;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb: a table of single transactions against a
// zero-wait slave, then hand-written multi-cycle corner cases.
module tb_mem_bus_arb;

  logic        clock;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        bus_err;

  mem_bus_arb_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  mem_bus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_addr      (lsu_addr),
    .lsu_size      (lsu_size),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .bus_err       (bus_err),
    .axi           (axi)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        is_lsu;
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_resp;
    logic [2:0]  exp_size;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard of what each client's rdata port should currently show
  logic [31:0] exp_ifu_rdata;
  logic [31:0] exp_lsu_rdata;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, id, act, exp);
    end
  endtask

  // {arvalid, awvalid, wvalid, rready, bready, ifu_respValid, lsu_respValid, bus_err}
  function automatic logic [31:0] ctl_bits();
    return 32'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
                ifu_respValid, lsu_respValid, bus_err});
  endfunction

  task automatic drop_reqs();
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
  endtask

  // one read-data beat from the slave, accepted on the next edge
  task automatic slave_r(input logic [31:0] data, input logic [1:0] resp);
    axi.rvalid = 1'b1;
    axi.rdata  = data;
    axi.rresp  = resp;
    @(negedge clock);
    axi.rvalid = 1'b0;
    axi.rdata  = 32'h0;
    axi.rresp  = 2'b00;
  endtask

  // one-edge AR handshake
  task automatic slave_ar();
    axi.arready = 1'b1;
    @(negedge clock);
    axi.arready = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int id);
    bit ok;
    int n;
    if (v.is_lsu) begin
      lsu_reqValid = 1'b1;
      lsu_addr     = v.addr;
      lsu_size     = v.size;
      lsu_wen      = v.wen;
      lsu_wdata    = v.wdata;
      lsu_wmask    = v.wmask;
    end else begin
      ifu_reqValid = 1'b1;
      ifu_addr     = v.addr;
    end
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n++;
      if (axi.arvalid || axi.awvalid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("addr_issued", id, 32'(ok), 32'd1);
    if (!ok) begin
      drop_reqs();
      return;
    end
    chk("addr_latency", id, n, 1);
    if (v.is_lsu && v.wen) begin
      chk("wr_valids", id, ctl_bits(), 32'b0110_0000);
      chk("awaddr", id, axi.awaddr, v.addr);
      chk("awsize", id, 32'(axi.awsize), 32'(v.exp_size));
      chk("wdata", id, axi.wdata, v.wdata);
      chk("wstrb", id, 32'(axi.wstrb), 32'(v.wmask));
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      @(negedge clock);
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      chk("wr_bready", id, ctl_bits(), 32'b0000_1000);
      axi.bvalid = 1'b1;
      axi.bresp  = v.slv_resp;
      @(negedge clock);
      axi.bvalid = 1'b0;
      axi.bresp  = 2'b00;
      chk("wr_resp", id, ctl_bits(), 32'({6'b000000, 1'b1, v.exp_err}));
    end else begin
      chk("rd_valids", id, ctl_bits(), 32'b1000_0000);
      chk("araddr", id, axi.araddr, v.addr);
      chk("arsize", id, 32'(axi.arsize), 32'(v.exp_size));
      slave_ar();
      chk("rd_rready", id, ctl_bits(), 32'b0001_0000);
      slave_r(v.slv_rdata, v.slv_resp);
      if (v.is_lsu) exp_lsu_rdata = v.slv_rdata;
      else          exp_ifu_rdata = v.slv_rdata;
      chk("rd_resp", id, ctl_bits(), 32'({5'b00000, !v.is_lsu, v.is_lsu, v.exp_err}));
    end
    chk("ifu_rdata", id, ifu_rdata, exp_ifu_rdata);
    chk("lsu_rdata", id, lsu_rdata, exp_lsu_rdata);
    drop_reqs();
    @(negedge clock);
    chk("pulse_end", id, ctl_bits(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog[0]: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t rv;

    //             lsu   wen   addr          size  wdata         wmask    slv_rdata     resp   size    err
    vecs[0] = '{1'b0, 1'b0, 32'h3000_0000, 2'd0, 32'h0000_0000, 4'b0000, 32'h0010_0093, 2'b00, 3'b010, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h8000_0001, 2'd0, 32'h0000_0000, 4'b0000, 32'h1122_3344, 2'b00, 3'b000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_0002, 2'd1, 32'h0000_0000, 4'b0000, 32'hCAFE_F00D, 2'b00, 3'b001, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h8000_0008, 2'd2, 32'h1234_5678, 4'b1111, 32'h0000_0000, 2'b00, 3'b010, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h8000_000C, 2'd2, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 2'b10, 3'b010, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h3000_0004, 2'd0, 32'h0000_0000, 4'b0000, 32'h0000_0013, 2'b00, 3'b010, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h8000_0003, 2'd0, 32'h7700_0000, 4'b1000, 32'h0000_0000, 2'b11, 3'b000, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 32'h8000_000E, 2'd1, 32'hBEEF_0000, 4'b1100, 32'h0000_0000, 2'b00, 3'b001, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 32'h3000_0008, 2'd0, 32'h0000_0000, 4'b0000, 32'hFFFF_FFFF, 2'b01, 3'b010, 1'b1};

    ifu_reqValid = 1'b0;
    ifu_addr     = 32'h0;
    lsu_reqValid = 1'b0;
    lsu_addr     = 32'h0;
    lsu_size     = 2'd0;
    lsu_wen      = 1'b0;
    lsu_wdata    = 32'h0;
    lsu_wmask    = 4'h0;
    axi.awready  = 1'b0;
    axi.wready   = 1'b0;
    axi.bvalid   = 1'b0;
    axi.bresp    = 2'b00;
    axi.arready  = 1'b0;
    axi.rvalid   = 1'b0;
    axi.rdata    = 32'h0;
    axi.rresp    = 2'b00;
    exp_ifu_rdata = 32'h0;
    exp_lsu_rdata = 32'h0;

    // reset state
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset_ctl", 0, ctl_bits(), 32'd0);
    chk("reset_ifu_rdata", 0, ifu_rdata, 32'h0);
    chk("reset_lsu_rdata", 0, lsu_rdata, 32'h0);
    chk("reset_araddr", 0, axi.araddr, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_idle", 0, ctl_bits(), 32'd0);

    // table of single transactions
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], i);
      $display("vector %0d: lsu=%0b wen=%0b addr=%h done", i, vecs[i].is_lsu, vecs[i].wen, vecs[i].addr);
    end

    // stray rvalid/bvalid while idle are ignored
    axi.rvalid = 1'b1;
    axi.bvalid = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("stray_ignored", 100, ctl_bits(), 32'd0);
    end
    axi.rvalid = 1'b0;
    axi.bvalid = 1'b0;
    $display("sequence stray rvalid/bvalid done");

    // store with W accepted two cycles before AW
    lsu_reqValid = 1'b1;
    lsu_wen      = 1'b1;
    lsu_addr     = 32'h8000_0004;
    lsu_size     = 2'd0;
    lsu_wdata    = 32'h0000_AB00;
    lsu_wmask    = 4'b0010;
    @(negedge clock);
    chk("stag_valids", 200, ctl_bits(), 32'b0110_0000);
    chk("stag_awaddr", 200, axi.awaddr, 32'h8000_0004);
    chk("stag_awsize", 200, 32'(axi.awsize), 32'd0);
    chk("stag_wstrb", 200, 32'(axi.wstrb), 32'b0010);
    axi.wready = 1'b1;
    @(negedge clock);
    axi.wready = 1'b0;
    chk("stag_w_done", 201, ctl_bits(), 32'b0100_0000);
    @(negedge clock);
    chk("stag_aw_held", 202, ctl_bits(), 32'b0100_0000);
    axi.awready = 1'b1;
    @(negedge clock);
    axi.awready = 1'b0;
    chk("stag_bready", 203, ctl_bits(), 32'b0000_1000);
    axi.bvalid = 1'b1;
    @(negedge clock);
    axi.bvalid = 1'b0;
    chk("stag_resp", 204, ctl_bits(), 32'b0000_0010);
    drop_reqs();
    lsu_wen = 1'b0;
    @(negedge clock);
    chk("stag_end", 205, ctl_bits(), 32'd0);
    $display("sequence staggered store done");

    // simultaneous requests: LSU first, then IFU
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h3000_0100;
    lsu_reqValid = 1'b1;
    lsu_wen      = 1'b0;
    lsu_addr     = 32'h8000_0100;
    lsu_size     = 2'd2;
    @(negedge clock);
    chk("both_first_ar", 300, ctl_bits(), 32'b1000_0000);
    chk("both_first_addr", 300, axi.araddr, 32'h8000_0100);
    slave_ar();
    slave_r(32'h5555_AAAA, 2'b00);
    exp_lsu_rdata = 32'h5555_AAAA;
    chk("both_lsu_resp", 301, ctl_bits(), 32'b0000_0010);
    chk("both_lsu_rdata", 301, lsu_rdata, exp_lsu_rdata);
    lsu_reqValid = 1'b0;
    @(negedge clock);
    chk("both_second_ar", 302, ctl_bits(), 32'b1000_0000);
    chk("both_second_addr", 302, axi.araddr, 32'h3000_0100);
    slave_ar();
    slave_r(32'h0000_0513, 2'b00);
    exp_ifu_rdata = 32'h0000_0513;
    chk("both_ifu_resp", 303, ctl_bits(), 32'b0000_0100);
    chk("both_ifu_rdata", 303, ifu_rdata, exp_ifu_rdata);
    chk("both_lsu_kept", 303, lsu_rdata, exp_lsu_rdata);
    drop_reqs();
    @(negedge clock);
    chk("both_end", 304, ctl_bits(), 32'd0);
    $display("sequence simultaneous requests done");

    // slave stalls AR for 5 cycles while the fetch address input wanders
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h3000_0400;
    @(negedge clock);
    chk("stall_ar", 400, ctl_bits(), 32'b1000_0000);
    for (int k = 0; k < 5; k++) begin
      ifu_addr = $urandom;
      @(negedge clock);
      chk("stall_arvalid", 401 + k, 32'(axi.arvalid), 32'd1);
      chk("stall_araddr", 401 + k, axi.araddr, 32'h3000_0400);
    end
    slave_ar();
    slave_r(32'h0041_0113, 2'b00);
    exp_ifu_rdata = 32'h0041_0113;
    chk("stall_resp", 406, ctl_bits(), 32'b0000_0100);
    chk("stall_rdata", 406, ifu_rdata, exp_ifu_rdata);
    drop_reqs();
    @(negedge clock);
    $display("sequence slave stall done");

    // reset while waiting for read data
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h3000_0300;
    @(negedge clock);
    chk("rst_ar", 500, ctl_bits(), 32'b1000_0000);
    slave_ar();
    chk("rst_in_rd_resp", 501, ctl_bits(), 32'b0001_0000);
    #2 reset = 1'b0;
    #1;
    exp_ifu_rdata = 32'h0;
    exp_lsu_rdata = 32'h0;
    chk("rst_async_ctl", 502, ctl_bits(), 32'd0);
    chk("rst_async_ifu_rdata", 502, ifu_rdata, 32'h0);
    chk("rst_async_lsu_rdata", 502, lsu_rdata, 32'h0);
    chk("rst_async_araddr", 502, axi.araddr, 32'h0);
    drop_reqs();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_idle", 503, ctl_bits(), 32'd0);
    rv = '{1'b0, 1'b0, 32'h3000_0500, 2'd0, 32'h0, 4'h0, 32'h0000_0067, 2'b00, 3'b010, 1'b0};
    run_txn(rv, 504);
    $display("sequence reset mid-read done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arb.md
Name: mem_bus_arb

Overview:
- Downstream of the CPU core. Consumes the core's two request ports (instruction fetch and load/store) and serialises them onto a single AXI4-Lite master port toward the SoC interconnect.
- One outstanding transaction at a time.
- Returns read data and a one-cycle response pulse to whichever client was granted.

Parameters:
- ADDR_W, 32, address width of both clients and the AXI port.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
ifu_reqValid  in  1  fetch request; held high until ifu_respValid
ifu_addr  in  ADDR_W  fetch address
ifu_respValid  out  1  one-cycle pulse: fetch done
ifu_rdata  out  DATA_W  fetched word; valid with ifu_respValid
lsu_reqValid  in  1  load/store request; held high until lsu_respValid
lsu_addr  in  ADDR_W  access address
lsu_size  in  2  0=byte, 1=half, 2=word
lsu_wen  in  1  1=store, 0=load
lsu_wdata  in  DATA_W  store data, already lane-aligned
lsu_wmask  in  DATA_W/8  byte strobes
lsu_respValid  out  1  one-cycle pulse: load/store done
lsu_rdata  out  DATA_W  raw bus word, not aligned
bus_err  out  1  one-cycle pulse alongside a respValid whose resp != OKAY
awvalid / awready / awaddr[ADDR_W] / awsize[3]  AXI write address
wvalid / wready / wdata[DATA_W] / wstrb[DATA_W/8]  AXI write data
bvalid / bready / bresp[2]  AXI write response
arvalid / arready / araddr[ADDR_W] / arsize[3]  AXI read address
rvalid / rready / rdata[DATA_W] / rresp[2]  AXI read data

Behaviour:
- All outputs are registered. Reset value of every output is 0, state is IDLE, and latched request fields are 0.
- States: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP.
- IDLE grant:
  - Sampled each cycle. lsu_reqValid has fixed priority over ifu_reqValid.
  - Grant latches client id, address, size, wen, wdata and wmask. Client inputs are ignored after grant.
- IDLE transitions:
  - Granted load or fetch -> RD_REQ, arvalid=1 next cycle.
  - Granted store -> WR_REQ, awvalid=1 and wvalid=1 next cycle.
- Size mapping: fetch arsize=3'b010. LSU arsize/awsize = {1'b0, lsu_size}.
- RD_REQ: hold arvalid and araddr stable until arready. On the handshake, arvalid=0, rready=1, go to RD_RESP.
- RD_RESP: on rvalid&&rready:
  - rready=0.
  - Capture rdata into the granted client's rdata register.
  - Pulse that client's respValid next cycle.
  - bus_err = (rresp != 0).
  - Return to IDLE.
- WR_REQ:
  - AW and W handshake independently. Each valid drops on its own handshake; aw_done and w_done flags track completion.
  - A same-cycle double handshake is legal.
  - When both are done, bready=1 and go to WR_RESP.
- WR_RESP: on bvalid&&bready, bready=0, pulse lsu_respValid, bus_err = (bresp != 0), return to IDLE.
- Latency with zero-wait slave:
  - Request seen at cycle N -> arvalid at N+1.
  - ar handshake at N+1 -> rvalid accepted at N+2 -> respValid at N+3.
- Response timing:
  - respValid is high exactly one cycle.
  - The client's rdata holds its value until the next response to that client.
  - The other client's outputs are unaffected.
- Back-to-back: the cycle respValid is high, the arbiter is in IDLE and may grant a new request the same cycle.
- Client reqValid dropped before grant: no transaction issued. Dropped after grant: transaction still completes and the response is still pulsed.
- Both requests pending: LSU served first. IFU served on the next IDLE cycle if still requested.
- No starvation guarantee beyond this: the core never holds both indefinitely.
- Reset asserted mid-transaction: immediate return to IDLE, all valid/ready/respValid to 0, transaction abandoned. The interconnect shares the reset.
- Stray rvalid or bvalid outside the matching state is ignored; rready/bready stay 0.
- bus_err does not block; the core decides the action.

Test Plan:
- Fetch, zero-wait slave: ifu_reqValid=1, ifu_addr=0x3000_0000, slave returns 0x0010_0093 -> araddr=0x3000_0000, arsize=2, ifu_rdata=0x0010_0093, ifu_respValid pulses exactly 3 cycles after request, lsu_respValid stays 0.
- Store, staggered readies: lsu_wen=1, addr 0x8000_0004, size=0, wdata=0x0000_AB00, wmask=4'b0010; wready 2 cycles before awready -> wvalid drops first, awvalid held, bready raised only after both, one lsu_respValid, bus_err=0.
- Simultaneous requests: ifu and lsu load asserted same cycle -> LSU ar issued first, lsu_respValid, then IFU ar issued, ifu_respValid; no overlap of arvalid.
- Error response: load with rresp=2'b10, rdata=0xDEAD_BEEF -> lsu_respValid=1 and bus_err=1 same cycle, lsu_rdata=0xDEAD_BEEF, next request proceeds normally.
- Reset mid-read: assert reset while in RD_RESP with rvalid low -> all outputs 0 asynchronously; after release, a new fetch completes correctly.
- Slave stall: arready held 0 for 5 cycles while ifu_addr input changes -> araddr stays at the latched value, arvalid continuously high until handshake.
